// File: rtl/riscv32ima_pkg.sv
// Shared constants and types for the RV32IMA load/store path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv32ima_pkg;

  localparam int XLEN     = 32;
  localparam int FUNC3_W  = 3;
  localparam int OPCODE_W = 7;

  // Major opcodes seen by the LSU; only LOAD and STORE touch memory.
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_AMO    = 7'b0101111;

  // Access width / signedness encodings.
  localparam logic [FUNC3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNC3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNC3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNC3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNC3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/riscv32ima_lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module riscv32ima_lsu_align
  import riscv32ima_pkg::*;
(
  input  logic [FUNC3_W-1:0] func3,
  input  logic [1:0]         off,
  input  logic [XLEN-1:0]    st_data,
  input  logic [XLEN-1:0]    ld_rdata,
  output logic [3:0]         be,
  output logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lane ignores off[0]; misaligned halves fold onto the aligned half.
  assign byte_sel = ld_rdata[{off, 3'b000} +: 8];
  assign half_sel = ld_rdata[{off[1], 4'b0000} +: 16];

  // Width decode; unlisted encodings behave as a full word.
  always_comb begin
    be      = 4'hF;
    wdata   = st_data;
    ld_data = ld_rdata;
    case (func3)
      F3_B, F3_BU: begin
        be      = 4'b0001 << off;
        wdata   = {4{st_data[7:0]}};
        ld_data = (func3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        be      = {off[1], off[1], ~off[1], ~off[1]};
        wdata   = {2{st_data[15:0]}};
        ld_data = (func3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv32ima_lsu.sv
// Load/store unit: one op at a time from execute, single-beat memory access, in-order result to writeback.
// Latency: pass-through accept->lsu_valid 1 cycle; load/store 1 + cycles to mem_ack + 1.
// Backpressure: ex_ready low in MEM/RESP; mem request and result held stable until mem_ack / lsu_ready.
module riscv32ima_lsu
  import riscv32ima_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int OPCODE_WIDTH   = 7,
  parameter int FUNC3_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [OPCODE_WIDTH-1:0]   ex_opcode,
  input  logic [FUNC3_WIDTH-1:0]    ex_func3,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_addr,
  input  logic [ADDR_WIDTH-1:0]     ex_mem_addr,
  input  logic [REG_DATA_WIDTH-1:0] ex_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [3:0]                mem_be,
  output logic [REG_DATA_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [REG_DATA_WIDTH-1:0] mem_rdata,
  output logic                      lsu_valid,
  input  logic                      lsu_ready,
  output logic [OPCODE_WIDTH-1:0]   lsu_opcode,
  output logic [REG_ADDR_WIDTH-1:0] lsu_reg_addr,
  output logic [ADDR_WIDTH-1:0]     lsu_mem_addr,
  output logic [REG_DATA_WIDTH-1:0] lsu_data
);

  lsu_state_t                state_q, state_d;
  logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
  logic [FUNC3_WIDTH-1:0]    func3_q, func3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  // Holds store/pass-through data on entry, replaced by the extended load value on ack.
  logic [REG_DATA_WIDTH-1:0] data_q, data_d;

  logic [3:0]                al_be;
  logic [REG_DATA_WIDTH-1:0] al_wdata;
  logic [REG_DATA_WIDTH-1:0] al_ld_data;

  // Steering runs off captured fields only, so memory outputs cannot glitch during MEM.
  riscv32ima_lsu_align u_align (
    .func3    (func3_q),
    .off      (addr_q[1:0]),
    .st_data  (data_q),
    .ld_rdata (mem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld_data)
  );

  assign ex_ready     = nrst && (state_q == IDLE);
  assign mem_req      = (state_q == MEM);
  assign mem_we       = (state_q == MEM) && (opcode_q == OPC_STORE);
  assign mem_be       = (state_q == MEM) ? al_be : 4'h0;
  assign mem_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata    = al_wdata;
  assign lsu_valid    = (state_q == RESP);
  assign lsu_opcode   = opcode_q;
  assign lsu_reg_addr = rd_q;
  assign lsu_mem_addr = addr_q;
  assign lsu_data     = data_q;

  // Next-state and capture logic for the IDLE -> MEM -> RESP sequence.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          opcode_d = ex_opcode;
          func3_d  = ex_func3;
          rd_d     = ex_reg_addr;
          addr_d   = ex_mem_addr;
          data_d   = ex_data;
          state_d  = is_mem_op(ex_opcode) ? MEM : RESP;
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (opcode_q == OPC_LOAD) data_d = al_ld_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (lsu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state resets; datapath registers are don't-care until captured.
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
    opcode_q <= opcode_d;
    func3_q  <= func3_d;
    rd_q     <= rd_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
  end

endmodule

// File: tb/tb_riscv32ima_lsu.sv
module tb_riscv32ima_lsu;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] LUI   = 7'b0110111;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_reg_addr;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [6:0]  lsu_opcode;
  logic [4:0]  lsu_reg_addr;
  logic [31:0] lsu_mem_addr;
  logic [31:0] lsu_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations collected by run_op for the test tasks to judge.
  logic        o_we, o_exrdy_accept, o_unstable, o_timeout, o_busy_rdy, o_after_rdy, o_after_vld;
  logic [31:0] o_addr, o_wdata, o_data, o_maddr;
  logic [3:0]  o_be;
  logic [6:0]  o_opc;
  logic [4:0]  o_rd;
  int          o_lat;

  always #5 clk = ~clk;

  riscv32ima_lsu dut (
    .clk(clk), .nrst(nrst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
    .ex_reg_addr(ex_reg_addr), .ex_mem_addr(ex_mem_addr), .ex_data(ex_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_opcode(lsu_opcode),
    .lsu_reg_addr(lsu_reg_addr), .lsu_mem_addr(lsu_mem_addr), .lsu_data(lsu_data)
  );

  // ---------------- reference model (access size arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(f3);
    return ((int'(addr % 4)) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << nbytes(f3)) - 1) << lane_base(f3, addr);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (nbytes(f3) == 1) return {24'b0, d[7:0]} * 32'h01010101;
    if (nbytes(f3) == 2) return {16'b0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [63:0] v, mask, sbit;
    int n;
    n    = nbytes(f3);
    mask = (64'd1 << (8 * n)) - 64'd1;
    sbit = 64'd1 << (8 * n - 1);
    v    = ({32'b0, rdata} >> (8 * lane_base(f3, addr))) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && ((v & sbit) != 0)) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, plays the memory and writeback sides, records what the DUT showed.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                        input int waits, input int rdy_wait);
    int cyc;
    o_timeout = 0; o_unstable = 0; o_busy_rdy = 0;
    o_exrdy_accept = ex_ready;
    ex_valid = 1; ex_opcode = opc; ex_func3 = f3; ex_reg_addr = rd;
    ex_mem_addr = addr; ex_data = data;
    step();
    cyc = 1;
    ex_valid = 0; ex_opcode = 7'($urandom); ex_func3 = 3'($urandom);
    ex_mem_addr = $urandom; ex_data = $urandom; ex_reg_addr = 5'($urandom);
    if (opc == LOAD || opc == STORE) begin
      if (!mem_req) o_timeout = 1;
      else begin
        o_we = mem_we; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        for (int w = 0; w < waits; w++) begin
          if (ex_ready || lsu_valid) o_busy_rdy = 1;
          step(); cyc++;
          if (!mem_req || mem_we !== o_we || mem_addr !== o_addr || mem_be !== o_be ||
              mem_wdata !== o_wdata) o_unstable = 1;
        end
        if (ex_ready) o_busy_rdy = 1;
        mem_ack = 1; mem_rdata = rdata;
        step(); cyc++;
        mem_ack = 0; mem_rdata = $urandom;
      end
    end
    while (!lsu_valid && cyc < 20) begin
      step(); cyc++;
    end
    if (!lsu_valid) o_timeout = 1;
    o_lat = cyc;
    o_data = lsu_data; o_opc = lsu_opcode; o_rd = lsu_reg_addr; o_maddr = lsu_mem_addr;
    for (int r = 0; r < rdy_wait; r++) begin
      if (ex_ready || mem_req) o_busy_rdy = 1;
      step();
      if (!lsu_valid || lsu_data !== o_data || lsu_opcode !== o_opc ||
          lsu_reg_addr !== o_rd || lsu_mem_addr !== o_maddr) o_unstable = 1;
    end
    if (ex_ready) o_busy_rdy = 1;
    lsu_ready = 1;
    step();
    lsu_ready = 0;
    o_after_rdy = ex_ready;
    o_after_vld = lsu_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nrst = 0;
    step(); step();
    n_checks++; if (ex_ready !== 1'b0) $display("FAIL reset_ex_ready got=%b exp=0", ex_ready); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else n_pass++;
    n_checks++; if (mem_be !== 4'h0) $display("FAIL reset_mem_be got=%h exp=0", mem_be); else n_pass++;
    n_checks++; if (lsu_valid !== 1'b0) $display("FAIL reset_lsu_valid got=%b exp=0", lsu_valid); else n_pass++;
    nrst = 1;
    step();
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL post_reset_ex_ready got=%b exp=1", ex_ready); else n_pass++;
  endtask

  task automatic test_lw_wait();
    run_op(LOAD, 3'b010, 5'd9, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
    n_checks++; if (o_timeout !== 1'b0) $display("FAIL lw_timeout got=%b exp=0", o_timeout); else n_pass++;
    n_checks++; if (o_exrdy_accept !== 1'b1) $display("FAIL lw_ex_ready got=%b exp=1", o_exrdy_accept); else n_pass++;
    n_checks++; if (o_be !== 4'hF) $display("FAIL lw_be got=%h exp=F", o_be); else n_pass++;
    n_checks++; if (o_we !== 1'b0) $display("FAIL lw_we got=%b exp=0", o_we); else n_pass++;
    n_checks++; if (o_addr !== 32'h100) $display("FAIL lw_addr got=%h exp=100", o_addr); else n_pass++;
    n_checks++; if (o_data !== 32'hDEADBEEF) $display("FAIL lw_data got=%h exp=DEADBEEF", o_data); else n_pass++;
    n_checks++; if (o_rd !== 5'd9) $display("FAIL lw_rd got=%0d exp=9", o_rd); else n_pass++;
    n_checks++; if (o_lat !== 4) $display("FAIL lw_latency got=%0d exp=4", o_lat); else n_pass++;
    n_checks++; if (o_unstable !== 1'b0 || o_busy_rdy !== 1'b0)
      $display("FAIL lw_hold got unstable=%b busy=%b exp=0/0", o_unstable, o_busy_rdy); else n_pass++;
  endtask

  task automatic test_load_ext();
    run_op(LOAD, 3'b000, 5'd1, 32'h103, 32'h0, 32'h80112233, 1, 0);
    n_checks++; if (o_data !== 32'hFFFFFF80) $display("FAIL lb_data got=%h exp=FFFFFF80", o_data); else n_pass++;
    n_checks++; if (o_be !== 4'b1000) $display("FAIL lb_be got=%b exp=1000", o_be); else n_pass++;
    run_op(LOAD, 3'b100, 5'd2, 32'h103, 32'h0, 32'h80112233, 0, 0);
    n_checks++; if (o_data !== 32'h00000080) $display("FAIL lbu_data got=%h exp=00000080", o_data); else n_pass++;
    run_op(LOAD, 3'b001, 5'd3, 32'h102, 32'h0, 32'h80015A5A, 0, 1);
    n_checks++; if (o_data !== 32'hFFFF8001) $display("FAIL lh_data got=%h exp=FFFF8001", o_data); else n_pass++;
    n_checks++; if (o_be !== 4'b1100) $display("FAIL lh_be got=%b exp=1100", o_be); else n_pass++;
    run_op(LOAD, 3'b101, 5'd4, 32'h102, 32'h0, 32'h80015A5A, 2, 0);
    n_checks++; if (o_data !== 32'h00008001) $display("FAIL lhu_data got=%h exp=00008001", o_data); else n_pass++;
  endtask

  task automatic test_store();
    run_op(STORE, 3'b000, 5'd0, 32'h201, 32'h000000A5, 32'h0, 1, 0);
    n_checks++; if (o_we !== 1'b1) $display("FAIL sb_we got=%b exp=1", o_we); else n_pass++;
    n_checks++; if (o_addr !== 32'h200) $display("FAIL sb_addr got=%h exp=200", o_addr); else n_pass++;
    n_checks++; if (o_be !== 4'b0010) $display("FAIL sb_be got=%b exp=0010", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got=%h exp=A5A5A5A5", o_wdata); else n_pass++;
    n_checks++; if (o_opc !== STORE || o_data !== 32'hA5)
      $display("FAIL sb_resp got opc=%b data=%h exp=%b/000000A5", o_opc, o_data, STORE); else n_pass++;
    run_op(STORE, 3'b001, 5'd0, 32'h202, 32'h00001234, 32'h0, 0, 0);
    n_checks++; if (o_be !== 4'b1100) $display("FAIL sh_be got=%b exp=1100", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'h12341234) $display("FAIL sh_wdata got=%h exp=12341234", o_wdata); else n_pass++;
  endtask

  task automatic test_passthrough();
    run_op(OPR, 3'b000, 5'd7, 32'h44, 32'd7, 32'h0, 0, 3);
    n_checks++; if (o_lat !== 1) $display("FAIL pt_latency got=%0d exp=1", o_lat); else n_pass++;
    n_checks++; if (o_data !== 32'd7 || o_rd !== 5'd7 || o_opc !== OPR)
      $display("FAIL pt_fields got data=%h rd=%0d opc=%b exp=7/7/%b", o_data, o_rd, o_opc, OPR); else n_pass++;
    n_checks++; if (o_unstable !== 1'b0) $display("FAIL pt_stable got=%b exp=0", o_unstable); else n_pass++;
    n_checks++; if (o_busy_rdy !== 1'b0) $display("FAIL pt_ex_ready_held got=%b exp=0", o_busy_rdy); else n_pass++;
    n_checks++; if (o_after_rdy !== 1'b1 || o_after_vld !== 1'b0)
      $display("FAIL pt_release got ex_ready=%b lsu_valid=%b exp=1/0", o_after_rdy, o_after_vld); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    ex_valid = 1; ex_opcode = LOAD; ex_func3 = 3'b010; ex_reg_addr = 5'd5;
    ex_mem_addr = 32'h300; ex_data = 0;
    step();
    ex_valid = 0;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_mid_req_before got=%b exp=1", mem_req); else n_pass++;
    nrst = 0;
    step();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mid_req got=%b exp=0", mem_req); else n_pass++;
    n_checks++; if (lsu_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", lsu_valid); else n_pass++;
    nrst = 1;
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (lsu_valid || mem_req) seen++;
      step();
    end
    n_checks++; if (seen !== 0) $display("FAIL stray_ack got=%0d exp=0 cycles with output", seen); else n_pass++;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL rst_mid_idle got=%b exp=1", ex_ready); else n_pass++;
  endtask

  task automatic test_zero_wait();
    run_op(LOAD, 3'b010, 5'd12, 32'h400, 32'h0, 32'hCAFEF00D, 0, 0);
    n_checks++; if (o_lat !== 2) $display("FAIL zw_latency got=%0d exp=2", o_lat); else n_pass++;
    n_checks++; if (o_data !== 32'hCAFEF00D) $display("FAIL zw_data got=%h exp=CAFEF00D", o_data); else n_pass++;
  endtask

  // Back-to-back random ops against the model.
  task automatic test_random();
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, data, rdata, exp_data;
    int waits, rw, exp_lat;
    logic        is_mem;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: opc = LOAD;
        1: opc = STORE;
        2: opc = OPR;
        default: opc = LUI;
      endcase
      f3 = 3'($urandom); rd = 5'($urandom); addr = $urandom; data = $urandom; rdata = $urandom;
      waits = $urandom_range(0, 3); rw = $urandom_range(0, 2);
      is_mem  = (opc == LOAD || opc == STORE);
      exp_lat = is_mem ? 2 + waits : 1;
      exp_data = (opc == LOAD) ? m_load(f3, addr, rdata) : data;
      run_op(opc, f3, rd, addr, data, rdata, waits, rw);
      n_checks++;
      if (o_timeout !== 1'b0 || o_unstable !== 1'b0 || o_busy_rdy !== 1'b0 || o_exrdy_accept !== 1'b1)
        $display("FAIL rnd%0d_protocol got to=%b unst=%b busy=%b acc=%b exp=0/0/0/1",
                 i, o_timeout, o_unstable, o_busy_rdy, o_exrdy_accept);
      else n_pass++;
      n_checks++;
      if (o_data !== exp_data || o_opc !== opc || o_rd !== rd || o_maddr !== addr || o_lat !== exp_lat)
        $display("FAIL rnd%0d_resp got d=%h op=%b rd=%0d a=%h lat=%0d exp d=%h op=%b rd=%0d a=%h lat=%0d",
                 i, o_data, o_opc, o_rd, o_maddr, o_lat, exp_data, opc, rd, addr, exp_lat);
      else n_pass++;
      if (is_mem) begin
        n_checks++;
        if (o_be !== m_be(f3, addr) || o_addr !== {addr[31:2], 2'b00} || o_we !== (opc == STORE) ||
            (opc == STORE && o_wdata !== m_wdata(f3, data)))
          $display("FAIL rnd%0d_mem got be=%b a=%h we=%b wd=%h exp be=%b a=%h we=%b wd=%h",
                   i, o_be, o_addr, o_we, o_wdata, m_be(f3, addr), {addr[31:2], 2'b00},
                   (opc == STORE), m_wdata(f3, data));
        else n_pass++;
      end
    end
  endtask

  initial begin
    nrst = 0; ex_valid = 0; ex_opcode = 0; ex_func3 = 0; ex_reg_addr = 0;
    ex_mem_addr = 0; ex_data = 0; mem_ack = 0; mem_rdata = 0; lsu_ready = 0;
    test_reset();
    test_lw_wait();
    test_load_ext();
    test_store();
    test_passthrough();
    test_reset_mid();
    test_zero_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
